// File: rtl/cpu_pkg.sv
// Shared CPU definitions: FSM state encodings, register constants and the
// pipeline control bundle driven by the hazard/stall controller.
package cpu_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TRAP     = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Pipeline enables, bubbles and flush, in one bundle
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic idex_bubble;
    logic memwb_bubble;
    logic ifid_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL  = ctrl_t'(7'b1111_000);
  localparam ctrl_t CTRL_FREEZE  = ctrl_t'(7'b0000_010);
  localparam ctrl_t CTRL_BRANCH  = ctrl_t'(7'b1111_101);
  localparam ctrl_t CTRL_LOADUSE = ctrl_t'(7'b0011_100);
  localparam ctrl_t CTRL_RESET   = ctrl_t'(7'b0000_110);

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall controller bundle.
// master: pipeline side (drives hazard inputs, receives controls).
// slave : controller side (reads hazard inputs, drives controls/status).
interface hazard_stall_ctrl_if #(
  parameter int unsigned PERF_W = 16
) ();

  logic [4:0]        IFIDRs;
  logic [4:0]        IFIDRt;
  logic              IFIDUsesRt;
  logic              IDEXMemRead;
  logic [4:0]        IDEXRt;
  logic              EXBranchTaken;
  logic              EXMEMMemAccess;
  logic              DMemReady;

  logic              PCWrite;
  logic              IFIDWrite;
  logic              IDEXWrite;
  logic              EXMEMWrite;
  logic              IDEXBubble;
  logic              MEMWBBubble;
  logic              IFIDFlush;
  logic              MemTimeout;
  logic [PERF_W-1:0] StallCycles;

  modport master (
    output IFIDRs, IFIDRt, IFIDUsesRt, IDEXMemRead, IDEXRt,
           EXBranchTaken, EXMEMMemAccess, DMemReady,
    input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IDEXBubble,
           MEMWBBubble, IFIDFlush, MemTimeout, StallCycles
  );

  modport slave (
    input  IFIDRs, IFIDRt, IFIDUsesRt, IDEXMemRead, IDEXRt,
           EXBranchTaken, EXMEMMemAccess, DMemReady,
    output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IDEXBubble,
           MEMWBBubble, IFIDFlush, MemTimeout, StallCycles
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts clock edges with inc=1, holds at all-ones.
// Ports: clk, rst_n (async active-low), inc, count[W-1:0].
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Increment unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage CPU: load-use stall,
// taken-branch squash and data-memory wait freeze with timeout trap.
// Ports: clk, rst_n (async active-low), hs (slave modport):
//   in : IFIDRs, IFIDRt, IFIDUsesRt, IDEXMemRead, IDEXRt, EXBranchTaken,
//        EXMEMMemAccess, DMemReady
//   out: PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IDEXBubble, MEMWBBubble,
//        IFIDFlush (Mealy), MemTimeout (sticky), StallCycles (saturating)
module hazard_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned PERF_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_stall_ctrl_if.slave    hs
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]  wait_cnt_d;
  logic              mem_timeout_q;
  logic              mem_timeout_d;

  logic              lu_c;
  logic              busy_c;
  logic              hold_c;
  ctrl_t             ctrl_c;
  logic              stall_inc_c;
  logic [PERF_W-1:0] stall_cnt;

  // Load-use: EX load writes a non-zero register that ID reads
  assign lu_c = hs.IDEXMemRead && (hs.IDEXRt != REG_ZERO) &&
                ((hs.IDEXRt == hs.IFIDRs) ||
                 (hs.IFIDUsesRt && (hs.IDEXRt == hs.IFIDRt)));

  assign busy_c = hs.EXMEMMemAccess && !hs.DMemReady;

  // While waiting, only DMemReady releases the freeze
  assign hold_c = (state_q == ST_MEM_WAIT) ? !hs.DMemReady : busy_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next-state logic; the wait counter reaching TIMEOUT traps
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (busy_c) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (hs.DMemReady) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d       = ST_TRAP;
          wait_cnt_d    = CNT_W'(TIMEOUT);
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Output logic: reset force, then freeze > branch > load-use > normal
  always_comb begin
    ctrl_c = CTRL_NORMAL;
    if (!rst_n) begin
      ctrl_c = CTRL_RESET;
    end else begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (hold_c) begin
            ctrl_c = CTRL_FREEZE;
          end else if (hs.EXBranchTaken) begin
            ctrl_c = CTRL_BRANCH;
          end else if (lu_c) begin
            ctrl_c = CTRL_LOADUSE;
          end
        end
        default: ctrl_c = CTRL_FREEZE;
      endcase
    end
  end

  assign stall_inc_c = !ctrl_c.pc_write;

  sat_counter #(
    .W (PERF_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc_c),
    .count (stall_cnt)
  );

  assign hs.PCWrite     = ctrl_c.pc_write;
  assign hs.IFIDWrite   = ctrl_c.ifid_write;
  assign hs.IDEXWrite   = ctrl_c.idex_write;
  assign hs.EXMEMWrite  = ctrl_c.exmem_write;
  assign hs.IDEXBubble  = ctrl_c.idex_bubble;
  assign hs.MEMWBBubble = ctrl_c.memwb_bubble;
  assign hs.IFIDFlush   = ctrl_c.ifid_flush;
  assign hs.MemTimeout  = mem_timeout_q;
  assign hs.StallCycles = stall_cnt;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage CPU. It handles the hazards that forwarding cannot resolve: load-use, taken-branch squash, and data-memory wait.
- It drives the PC and pipeline-register write enables, bubbles and flushes.
- It runs an FSM for multi-cycle data-memory accesses, with a timeout trap and a stall-cycle performance counter.

Parameters:
- TIMEOUT, 64, max consecutive data-memory wait cycles before trap (>=2).
- PERF_W, 16, width of saturating stall-cycle counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- IFIDRs  in  5  source reg rs of instruction in ID.
- IFIDRt  in  5  source reg rt of instruction in ID.
- IFIDUsesRt  in  1  ID instruction reads rt (R-type, store, beq).
- IDEXMemRead  in  1  instruction in EX is a load.
- IDEXRt  in  5  load destination in EX.
- EXBranchTaken  in  1  branch in EX resolved taken.
- EXMEMMemAccess  in  1  instruction in MEM issues dmem read/write.
- DMemReady  in  1  dmem completes access this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IDEXWrite  out  1  ID/EX register enable.
- EXMEMWrite  out  1  EX/MEM register enable.
- IDEXBubble  out  1  zero control fields entering ID/EX.
- MEMWBBubble  out  1  zero control fields entering MEM/WB.
- IFIDFlush  out  1  squash IF/ID contents.
- MemTimeout  out  1  sticky trap flag.
- StallCycles  out  PERF_W  saturating count of cycles with PCWrite=0.

Behaviour:
- Reset (async, rst_n=0): state=RUN, wait counter=0, MemTimeout=0, StallCycles=0. While rst_n is low, outputs are forced: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMWrite=0, IDEXBubble=1, MEMWBBubble=1, IFIDFlush=0. Reset mid-wait aborts everything.
- Combinational terms:
  - lu = IDEXMemRead & (IDEXRt!=0) & ((IDEXRt==IFIDRs) | (IFIDUsesRt & (IDEXRt==IFIDRt))).
  - busy = EXMEMMemAccess & ~DMemReady.
- Outputs are Mealy: a function of state plus the current inputs.
- Priority in RUN: freeze > branch > load-use > normal.
  - Freeze (busy=1): PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite all 0; MEMWBBubble=1; IDEXBubble=0; IFIDFlush=0.
  - Branch (EXBranchTaken=1, busy=0): all enables 1, IFIDFlush=1, IDEXBubble=1. Any simultaneous lu is ignored because the consumer is squashed.
  - Load-use (lu=1, busy=0, no branch): PCWrite=0, IFIDWrite=0, IDEXBubble=1, IDEXWrite=1, EXMEMWrite=1. Exactly one stall cycle, since the bubble clears IDEXMemRead next cycle.
  - Normal: all enables 1, bubbles and flush 0.
- FSM states: RUN, MEM_WAIT, TRAP.
  - RUN -> MEM_WAIT when busy=1 (the entry cycle already freezes); wait counter loads 1.
  - MEM_WAIT: freeze outputs while DMemReady=0; counter increments each cycle.
  - MEM_WAIT -> RUN on the cycle DMemReady=1. That cycle is evaluated with RUN priority rules and busy=0, so a pending branch or load-use acts in that same cycle.
  - MEM_WAIT -> TRAP when counter reaches TIMEOUT and DMemReady=0. MemTimeout is set and stays 1 until reset.
  - TRAP: freeze outputs permanently, regardless of inputs. Exit only by reset.
- DMemReady=1 on the first access cycle causes no freeze and no state change.
- EXBranchTaken during a freeze: no flush until unfrozen. EX is held, so the branch remains asserted and flushes on the release cycle.
- StallCycles increments on each clk edge where PCWrite=0 and rst_n=1, including TRAP. It saturates at all-ones with no wrap.
- Wait counter width: clog2(TIMEOUT+1).

Decomposition:
- Shared cpu_pkg holds:
  - state encoding localparams ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_TRAP=2'd2;
  - REG_ZERO=5'd0.
- Sub-module sat_counter (parameter W, ports clk, rst_n, inc, count) for StallCycles. The wait counter stays inline.

Test Plan:
- lw $2 in EX (IDEXMemRead=1, IDEXRt=2), IFIDRs=2 -> one cycle with PCWrite=0, IFIDWrite=0, IDEXBubble=1; the next cycle is all-normal; StallCycles=1.
- IDEXRt=0 with IDEXMemRead=1, IFIDRs=0 -> no stall. Separately, IFIDRt=2 with IFIDUsesRt=0 -> no stall.
- EXBranchTaken=1 together with a load-use match -> IFIDFlush=1, IDEXBubble=1, PCWrite=1, no stall cycle.
- EXMEMMemAccess=1, DMemReady low for 3 cycles then high -> 3 frozen cycles (enables 0, MEMWBBubble=1); release on the 4th cycle; StallCycles=3; state back to RUN.
- TIMEOUT=4, DMemReady held 0 -> TRAP entered after 4 frozen cycles; MemTimeout=1 stays set even after DMemReady=1; rst_n pulse clears it to 0.
- PERF_W=3, DMemReady held 0 with TIMEOUT=64 for 10 cycles -> StallCycles saturates at 7. rst_n asserted mid-wait -> outputs forced to reset values immediately, StallCycles=0.
